// File: rtl/iq_dispatch.sv
// Dispatch / register-read stage in front of the issue queue.
// Two-stage valid/ready pipe: S1 reads the PRF, S2 registers the issue-queue entry.
module iq_dispatch #(
    parameter int PREG_BITS = 6,
    parameter int ROB_BITS  = 6,
    parameter int DATA_W    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,

    input  logic                 rn_valid,
    output logic                 rn_ready,
    input  logic [PREG_BITS-1:0] rn_phys_dest,
    input  logic [PREG_BITS-1:0] rn_phys_rs1,
    input  logic [PREG_BITS-1:0] rn_phys_rs2,
    input  logic [6:0]           rn_opcode,
    input  logic [DATA_W-1:0]    rn_immediate,
    input  logic [ROB_BITS-1:0]  rn_rob_index,

    output logic [PREG_BITS-1:0] prf_rs1_addr,
    input  logic [DATA_W-1:0]    prf_rs1_data,
    output logic [PREG_BITS-1:0] prf_rs2_addr,
    input  logic [DATA_W-1:0]    prf_rs2_data,

    input  logic                 cdb_valid,
    input  logic [PREG_BITS-1:0] cdb_tag,
    input  logic [DATA_W-1:0]    cdb_value,

    output logic                 iq_write_enable,
    input  logic                 iq_valid,
    output logic [PREG_BITS-1:0] iq_phys_dest,
    output logic [PREG_BITS-1:0] iq_phys_rs1,
    output logic [PREG_BITS-1:0] iq_phys_rs2,
    output logic [DATA_W-1:0]    iq_phys_rs1_val,
    output logic [DATA_W-1:0]    iq_phys_rs2_val,
    output logic [6:0]           iq_opcode,
    output logic [DATA_W-1:0]    iq_immediate,
    output logic [ROB_BITS-1:0]  iq_rob_index
);

    logic                 s1_valid;
    logic [PREG_BITS-1:0] s1_dest;
    logic [PREG_BITS-1:0] s1_rs1;
    logic [PREG_BITS-1:0] s1_rs2;
    logic [6:0]           s1_opcode;
    logic [DATA_W-1:0]    s1_imm;
    logic [ROB_BITS-1:0]  s1_rob;

    logic                 s2_valid;
    logic [PREG_BITS-1:0] s2_dest;
    logic [PREG_BITS-1:0] s2_rs1;
    logic [PREG_BITS-1:0] s2_rs2;
    logic [DATA_W-1:0]    s2_rs1_val;
    logic [DATA_W-1:0]    s2_rs2_val;
    logic [6:0]           s2_opcode;
    logic [DATA_W-1:0]    s2_imm;
    logic [ROB_BITS-1:0]  s2_rob;

    logic                 s2_adv;
    logic                 s1_adv;
    logic                 accept;
    logic [DATA_W-1:0]    rs1_read_val;
    logic [DATA_W-1:0]    rs2_read_val;
    logic [DATA_W-1:0]    rs1_snoop_val;
    logic [DATA_W-1:0]    rs2_snoop_val;

    // x0 is hard zero and never takes a bypass; otherwise CDB beats the PRF.
    function automatic logic [DATA_W-1:0] read_src(
        input logic [PREG_BITS-1:0] tag,
        input logic [DATA_W-1:0]    prf_val
    );
        if (tag == '0)
            return '0;
        else if (cdb_valid && (cdb_tag == tag))
            return cdb_value;
        else
            return prf_val;
    endfunction

    function automatic logic [DATA_W-1:0] snoop_src(
        input logic [PREG_BITS-1:0] tag,
        input logic [DATA_W-1:0]    held_val
    );
        if ((tag != '0) && cdb_valid && (cdb_tag == tag))
            return cdb_value;
        else
            return held_val;
    endfunction

    always_comb begin
        s2_adv        = !s2_valid || iq_valid;
        s1_adv        = s1_valid && s2_adv;
        rn_ready      = !flush && (!s1_valid || s2_adv);
        accept        = rn_valid && rn_ready;
        rs1_read_val  = read_src(s1_rs1, prf_rs1_data);
        rs2_read_val  = read_src(s1_rs2, prf_rs2_data);
        rs1_snoop_val = snoop_src(s2_rs1, s2_rs1_val);
        rs2_snoop_val = snoop_src(s2_rs2, s2_rs2_val);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_dest    <= '0;
            s1_rs1     <= '0;
            s1_rs2     <= '0;
            s1_opcode  <= '0;
            s1_imm     <= '0;
            s1_rob     <= '0;
            s2_valid   <= 1'b0;
            s2_dest    <= '0;
            s2_rs1     <= '0;
            s2_rs2     <= '0;
            s2_rs1_val <= '0;
            s2_rs2_val <= '0;
            s2_opcode  <= '0;
            s2_imm     <= '0;
            s2_rob     <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid  <= 1'b1;
                s1_dest   <= rn_phys_dest;
                s1_rs1    <= rn_phys_rs1;
                s1_rs2    <= rn_phys_rs2;
                s1_opcode <= rn_opcode;
                s1_imm    <= rn_immediate;
                s1_rob    <= rn_rob_index;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end

            if (s1_adv) begin
                s2_valid   <= 1'b1;
                s2_dest    <= s1_dest;
                s2_rs1     <= s1_rs1;
                s2_rs2     <= s1_rs2;
                s2_rs1_val <= rs1_read_val;
                s2_rs2_val <= rs2_read_val;
                s2_opcode  <= s1_opcode;
                s2_imm     <= s1_imm;
                s2_rob     <= s1_rob;
            end else if (s2_adv) begin
                s2_valid <= 1'b0;
            end else begin
                // Stalled entry keeps listening so it never issues with a stale value.
                s2_rs1_val <= rs1_snoop_val;
                s2_rs2_val <= rs2_snoop_val;
            end
        end
    end

    assign prf_rs1_addr    = s1_rs1;
    assign prf_rs2_addr    = s1_rs2;

    assign iq_write_enable = s2_valid;
    assign iq_phys_dest    = s2_valid ? s2_dest    : '0;
    assign iq_phys_rs1     = s2_valid ? s2_rs1     : '0;
    assign iq_phys_rs2     = s2_valid ? s2_rs2     : '0;
    assign iq_phys_rs1_val = s2_valid ? s2_rs1_val : '0;
    assign iq_phys_rs2_val = s2_valid ? s2_rs2_val : '0;
    assign iq_opcode       = s2_valid ? s2_opcode  : '0;
    assign iq_immediate    = s2_valid ? s2_imm     : '0;
    assign iq_rob_index    = s2_valid ? s2_rob     : '0;

endmodule

// File: tb/tb_iq_dispatch.sv
// Bench for iq_dispatch: directed scenarios then random traffic, checked against
// a 2-deep in-order FIFO model and a PRF "truth" array that CDB broadcasts update.
module tb_iq_dispatch;
    localparam int PB = 6;
    localparam int RB = 6;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          rn_valid;
    logic          rn_ready;
    logic [PB-1:0] rn_phys_dest;
    logic [PB-1:0] rn_phys_rs1;
    logic [PB-1:0] rn_phys_rs2;
    logic [6:0]    rn_opcode;
    logic [DW-1:0] rn_immediate;
    logic [RB-1:0] rn_rob_index;
    logic [PB-1:0] prf_rs1_addr;
    logic [DW-1:0] prf_rs1_data;
    logic [PB-1:0] prf_rs2_addr;
    logic [DW-1:0] prf_rs2_data;
    logic          cdb_valid;
    logic [PB-1:0] cdb_tag;
    logic [DW-1:0] cdb_value;
    logic          iq_write_enable;
    logic          iq_valid;
    logic [PB-1:0] iq_phys_dest;
    logic [PB-1:0] iq_phys_rs1;
    logic [PB-1:0] iq_phys_rs2;
    logic [DW-1:0] iq_phys_rs1_val;
    logic [DW-1:0] iq_phys_rs2_val;
    logic [6:0]    iq_opcode;
    logic [DW-1:0] iq_immediate;
    logic [RB-1:0] iq_rob_index;

    iq_dispatch #(.PREG_BITS(PB), .ROB_BITS(RB), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .rn_valid(rn_valid), .rn_ready(rn_ready),
        .rn_phys_dest(rn_phys_dest), .rn_phys_rs1(rn_phys_rs1), .rn_phys_rs2(rn_phys_rs2),
        .rn_opcode(rn_opcode), .rn_immediate(rn_immediate), .rn_rob_index(rn_rob_index),
        .prf_rs1_addr(prf_rs1_addr), .prf_rs1_data(prf_rs1_data),
        .prf_rs2_addr(prf_rs2_addr), .prf_rs2_data(prf_rs2_data),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .iq_write_enable(iq_write_enable), .iq_valid(iq_valid),
        .iq_phys_dest(iq_phys_dest), .iq_phys_rs1(iq_phys_rs1), .iq_phys_rs2(iq_phys_rs2),
        .iq_phys_rs1_val(iq_phys_rs1_val), .iq_phys_rs2_val(iq_phys_rs2_val),
        .iq_opcode(iq_opcode), .iq_immediate(iq_immediate), .iq_rob_index(iq_rob_index)
    );

    always #5 clk = ~clk;

    // Architectural view of the register file; a broadcast lands in it at the edge.
    logic [DW-1:0] truth [64];
    assign prf_rs1_data = truth[prf_rs1_addr];
    assign prf_rs2_data = truth[prf_rs2_addr];

    typedef struct {
        logic [PB-1:0] dest;
        logic [PB-1:0] rs1;
        logic [PB-1:0] rs2;
        logic [6:0]    op;
        logic [DW-1:0] imm;
        logic [RB-1:0] rob;
        bit            vis;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   passed = 0;
    int   fails  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_outputs(input bit vis, input ent_t e);
        chk("iq_write_enable", 64'(iq_write_enable), 64'(vis));
        chk("iq_phys_dest",    64'(iq_phys_dest),    vis ? 64'(e.dest) : 64'd0);
        chk("iq_phys_rs1",     64'(iq_phys_rs1),     vis ? 64'(e.rs1)  : 64'd0);
        chk("iq_phys_rs2",     64'(iq_phys_rs2),     vis ? 64'(e.rs2)  : 64'd0);
        chk("iq_phys_rs1_val", 64'(iq_phys_rs1_val), vis ? 64'(truth[e.rs1]) : 64'd0);
        chk("iq_phys_rs2_val", 64'(iq_phys_rs2_val), vis ? 64'(truth[e.rs2]) : 64'd0);
        chk("iq_opcode",       64'(iq_opcode),       vis ? 64'(e.op)   : 64'd0);
        chk("iq_immediate",    64'(iq_immediate),    vis ? 64'(e.imm)  : 64'd0);
        chk("iq_rob_index",    64'(iq_rob_index),    vis ? 64'(e.rob)  : 64'd0);
    endtask

    // One clock: check current outputs against the model, clock, then advance the model.
    task automatic tick();
        ent_t e;
        ent_t h;
        ent_t nw;
        bit   vis;
        bit   pop;
        bit   push;
        bit   ready_exp;
        int   idx;
        #1;
        vis       = (q.size() > 0) && q[0].vis;
        ready_exp = !flush && ((q.size() < 2) || iq_valid);
        chk("rn_ready", 64'(rn_ready), 64'(ready_exp));
        e = vis ? q[0] : '{dest:'0, rs1:'0, rs2:'0, op:'0, imm:'0, rob:'0, vis:0};
        chk_outputs(vis, e);
        idx = vis ? 1 : 0;
        if (q.size() > idx) begin
            chk("prf_rs1_addr", 64'(prf_rs1_addr), 64'(q[idx].rs1));
            chk("prf_rs2_addr", 64'(prf_rs2_addr), 64'(q[idx].rs2));
        end
        pop  = vis && iq_valid;
        push = rn_valid && ready_exp;
        nw   = '{dest:rn_phys_dest, rs1:rn_phys_rs1, rs2:rn_phys_rs2, op:rn_opcode,
                 imm:rn_immediate, rob:rn_rob_index, vis:0};
        @(posedge clk);
        #1;
        if (flush) begin
            q.delete();
        end else begin
            if (pop) q.delete(0);
            if (q.size() > 0) begin
                h = q.pop_front();
                h.vis = 1;
                q.push_front(h);
            end
            if (push) q.push_back(nw);
        end
        if (cdb_valid && (cdb_tag != '0)) truth[cdb_tag] = cdb_value;
    endtask

    task automatic set_rn(input int rs1, input int rs2, input int rob);
        rn_valid     = 1'b1;
        rn_phys_dest = PB'($urandom_range(1, 63));
        rn_phys_rs1  = PB'(rs1);
        rn_phys_rs2  = PB'(rs2);
        rn_opcode    = 7'($urandom);
        rn_immediate = $urandom;
        rn_rob_index = RB'(rob);
    endtask

    task automatic idle();
        rn_valid  = 1'b0;
        cdb_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic cdb(input int tag, input logic [DW-1:0] val);
        cdb_valid = 1'b1;
        cdb_tag   = PB'(tag);
        cdb_value = val;
    endtask

    task automatic check_reset_state(input string tag);
        ent_t z;
        z = '{dest:'0, rs1:'0, rs2:'0, op:'0, imm:'0, rob:'0, vis:0};
        chk({tag, "_rn_ready"}, 64'(rn_ready), 64'd1);
        chk({tag, "_prf_rs1_addr"}, 64'(prf_rs1_addr), 64'd0);
        chk({tag, "_prf_rs2_addr"}, 64'(prf_rs2_addr), 64'd0);
        chk_outputs(0, z);
    endtask

    task automatic mid_reset();
        flush = 1'b0;
        #2 reset = 1'b1;
        #1;
        check_reset_state("mid_reset");
        reset = 1'b0;
        q.delete();
    endtask

    initial begin
        truth[0] = '0;
        for (int i = 1; i < 64; i++) truth[i] = $urandom;
        reset = 1'b1; flush = 1'b0; iq_valid = 1'b0;
        rn_valid = 1'b0; rn_phys_dest = '0; rn_phys_rs1 = '0; rn_phys_rs2 = '0;
        rn_opcode = '0; rn_immediate = '0; rn_rob_index = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset = 1'b0;

        // Single op, no bypass
        truth[5] = 32'h11;
        truth[9] = 32'h22;
        iq_valid = 1'b1;
        set_rn(5, 9, 1);
        tick();
        idle();
        chk("t1_we_after_accept", 64'(iq_write_enable), 64'd0);
        tick();
        chk("t1_we_next", 64'(iq_write_enable), 64'd1);
        chk("t1_rs1_val", 64'(iq_phys_rs1_val), 64'h11);
        chk("t1_rs2_val", 64'(iq_phys_rs2_val), 64'h22);
        tick();

        // S1 bypass
        set_rn(5, 9, 2);
        tick();
        idle();
        cdb(5, 32'hABCD);
        tick();
        chk("t2_bypass", 64'(iq_phys_rs1_val), 64'hABCD);
        idle();
        tick();

        // x0 source ignores a tag-0 broadcast
        set_rn(0, 9, 3);
        tick();
        idle();
        cdb(0, 32'hFF);
        tick();
        chk("t3_x0", 64'(iq_phys_rs1_val), 64'h0);
        idle();
        tick();

        // Backpressure then drain
        iq_valid = 1'b0;
        set_rn(1, 2, 11);
        tick();
        set_rn(3, 4, 12);
        tick();
        chk("t4_full_ready", 64'(rn_ready), 64'd0);
        chk("t4_hold_op1", 64'(iq_rob_index), 64'd11);
        set_rn(5, 6, 13);
        tick();
        chk("t4_still_op1", 64'(iq_rob_index), 64'd11);
        iq_valid = 1'b1;
        tick();
        chk("t4_op2_next", 64'(iq_rob_index), 64'd12);
        set_rn(7, 1, 14);
        tick();
        chk("t4_op3_next", 64'(iq_rob_index), 64'd13);
        idle();
        tick();
        chk("t4_op4_next", 64'(iq_rob_index), 64'd14);
        tick();
        tick();

        // Stall snoop in S2
        iq_valid = 1'b0;
        set_rn(1, 9, 20);
        tick();
        idle();
        tick();
        cdb(9, 32'h77);
        tick();
        chk("t5_snoop", 64'(iq_phys_rs2_val), 64'h77);
        idle();
        iq_valid = 1'b1;
        tick();
        tick();

        // Flush with both stages full, then async reset mid-stream
        iq_valid = 1'b0;
        set_rn(2, 3, 30);
        tick();
        set_rn(4, 5, 31);
        tick();
        idle();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t6_flush_we", 64'(iq_write_enable), 64'd0);
        iq_valid = 1'b1;
        tick();
        chk("t6_no_ghost", 64'(iq_write_enable), 64'd0);
        iq_valid = 1'b0;
        set_rn(6, 7, 32);
        tick();
        set_rn(1, 2, 33);
        tick();
        idle();
        mid_reset();
        tick();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rn_valid     = ($urandom_range(0, 9) < 7);
            rn_phys_dest = PB'($urandom_range(0, 63));
            rn_phys_rs1  = PB'($urandom_range(0, 7));
            rn_phys_rs2  = PB'($urandom_range(0, 7));
            rn_opcode    = 7'($urandom);
            rn_immediate = $urandom;
            rn_rob_index = RB'($urandom);
            cdb_valid    = 1'($urandom_range(0, 1));
            cdb_tag      = PB'($urandom_range(0, 7));
            cdb_value    = $urandom;
            iq_valid     = ($urandom_range(0, 9) < 6);
            flush        = ($urandom_range(0, 49) == 0);
            tick();
            if (i == 300) mid_reset();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
